// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone shared-bus arbiter and its bus muxes.
//   clog2         : ceiling log2 for deriving index/counter widths (clog2(1) = 0)
//   MAX_MASTERS   : largest supported requester count
//   onehot_to_idx : one-hot grant vector to binary index
//   arb_dec_e     : per-cycle arbitration decision
package wb_arb_pkg;

  localparam int unsigned MAX_MASTERS = 16;
  localparam int unsigned MAX_IDX_W   = 4;

  typedef enum logic [1:0] {
    DecHold,
    DecForce,
    DecRelease,
    DecPark
  } arb_dec_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // OR-reduce of set-bit positions; exact for a one-hot input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority picker.
// Scans vec starting at start+1, start+2, ... modulo N (start itself is scanned last)
// and returns the first set bit.
//   vec    in  N      candidate vector
//   start  in  IDX_W  index the scan rotates away from
//   onehot out N      selected bit, one-hot (zero when vec is zero)
//   idx    out IDX_W  binary index of onehot
//   found  out 1      vec had at least one set bit
module wb_rr_pick import wb_arb_pkg::*; #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = IDX_W'((32'(start) + k) % N);
      if (!found && vec[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
      end
    end
  end

  assign idx = IDX_W'(onehot_to_idx(MAX_MASTERS'(onehot)));

endmodule

// File: rtl/wb_rr_arb_n.sv
// Round-robin Wishbone shared-bus arbiter for NUM_MASTERS requesters with a bounded
// hold time, per-owner lock and binary grant index.
//   clk          in  1            clock
//   rst          in  1            asynchronous, active-high reset
//   request      in  NUM_MASTERS  per-master cyc
//   lock         in  NUM_MASTERS  per-master lock; only the current owner's bit matters
//   grant        out NUM_MASTERS  registered one-hot grant
//   grant_idx    out IDX_W        registered binary index of grant
//   grant_active out 1            request of the current owner (combinational)
//   forced_rot   out 1            pulse on the cycle a hold-expiry rotation becomes visible
module wb_rr_arb_n import wb_arb_pkg::*; #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MAX_HOLD    = 8,
  localparam int unsigned IDX_W = clog2(NUM_MASTERS),
  localparam int unsigned CNT_W = (clog2(MAX_HOLD + 1) > 0) ? clog2(MAX_HOLD + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] request,
  input  logic [NUM_MASTERS-1:0] lock,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_active,
  output logic                   forced_rot
);

  // Counter value on which an unlocked owner is rotated away; 0 when unlimited.
  localparam int unsigned  HoldLast  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HoldLastC = CNT_W'(HoldLast);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   forced_rot_q, forced_rot_d;

  logic                   cur_req, cur_lock;
  logic [NUM_MASTERS-1:0] others, pick_vec, pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   hold_ok;
  arb_dec_e               dec;

  assign cur_req  = request[idx_q];
  assign cur_lock = lock[idx_q];
  assign others   = request & ~grant_q;
  // An active owner can only hand over to someone else; otherwise anyone may win.
  assign pick_vec = cur_req ? others : request;

  wb_rr_pick #(
    .N(NUM_MASTERS)
  ) u_pick (
    .vec   (pick_vec),
    .start (idx_q),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // pick_found means "others != 0" when the owner requests, "request != 0" otherwise.
  always_comb begin
    hold_ok = !pick_found || cur_lock || (MAX_HOLD == 0) || (hold_cnt_q < HoldLastC);
    if (cur_req) begin
      dec = hold_ok ? DecHold : DecForce;
    end else if (pick_found) begin
      dec = DecRelease;
    end else begin
      dec = DecPark;
    end
  end

  always_comb begin
    grant_d      = grant_q;
    idx_d        = idx_q;
    hold_cnt_d   = '0;
    forced_rot_d = 1'b0;
    unique case (dec)
      DecHold: begin
        hold_cnt_d = (hold_cnt_q < HoldLastC) ? hold_cnt_q + CNT_W'(1) : hold_cnt_q;
      end
      DecForce: begin
        grant_d      = pick_oh;
        idx_d        = pick_idx;
        forced_rot_d = 1'b1;
      end
      DecRelease: begin
        grant_d = pick_oh;
        idx_d   = pick_idx;
      end
      DecPark: begin
        // Park on the last owner so its next request needs no arbitration cycle.
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= NUM_MASTERS'(1);
      idx_q        <= '0;
      hold_cnt_q   <= '0;
      forced_rot_q <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      hold_cnt_q   <= hold_cnt_d;
      forced_rot_q <= forced_rot_d;
    end
  end

  assign grant        = grant_q;
  assign grant_idx    = idx_q;
  assign grant_active = cur_req;
  assign forced_rot   = forced_rot_q;

endmodule
